// File: rtl/ysyx_23060136_mem_lsu.sv
// Load/store unit: one memory transaction at a time over a simple AR/R + W/B bus.
// Results (aligned and extended) are handed to WBU over a valid/ready handshake.
module ysyx_23060136_mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXU_valid,
    output logic              LSU_ready,
    input  logic [ADDR_W-1:0] EXU_ALU_ALUout,
    input  logic [31:0]       EXU_rs2_data,
    input  logic              EXU_load,
    input  logic              EXU_store,
    input  logic [2:0]        EXU_funct3,
    output logic [ADDR_W-1:0] LSU_addr,
    output logic              LSU_arvalid,
    input  logic              LSU_arready,
    input  logic              LSU_rvalid,
    input  logic [31:0]       LSU_rdata,
    input  logic [1:0]        LSU_rresp,
    output logic              LSU_rready,
    output logic              LSU_wvalid,
    output logic [31:0]       LSU_wdata,
    output logic [3:0]        LSU_wstrb,
    input  logic              LSU_wready,
    input  logic              LSU_bvalid,
    input  logic [1:0]        LSU_bresp,
    output logic              LSU_bready,
    output logic              LSU_valid,
    input  logic              WBU_ready,
    output logic [31:0]       LSU_result,
    output logic              LSU_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t     state_r;
    logic [2:0] funct3_r;
    logic [1:0] a_lo_r;
    logic       mem_s;
    logic       illegal_s;
    logic       misalign_s;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a_lo);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << a_lo;
            2'b01:   store_strb = 4'b0011 << {a_lo[1], 1'b0};
            2'b10:   store_strb = 4'b1111;
            default: store_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   store_data = {4{rs2[7:0]}};
            2'b01:   store_data = {2{rs2[15:0]}};
            2'b10:   store_data = rs2;
            default: store_data = 32'h0000_0000;
        endcase
    endfunction

    // Halfword lanes are always even-aligned here, so a byte-granular shift serves both widths.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a_lo,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {a_lo, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extend = {24'h00_0000, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_extend = {16'h0000, sh[15:0]};
            3'b010:  load_extend = rdata;
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    assign mem_s      = EXU_load | EXU_store;
    assign illegal_s  = (EXU_load & EXU_store) |
                        (mem_s & ((EXU_funct3 == 3'b011) | (EXU_funct3[2:1] == 2'b11)));
    assign misalign_s = mem_s & (((EXU_funct3[1:0] == 2'b01) & EXU_ALU_ALUout[0]) |
                                 ((EXU_funct3[1:0] == 2'b10) & (EXU_ALU_ALUout[1:0] != 2'b00)));

    // Control FSM; every bus and WBU output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            funct3_r    <= 3'b000;
            a_lo_r      <= 2'b00;
            LSU_ready   <= 1'b1;
            LSU_addr    <= '0;
            LSU_arvalid <= 1'b0;
            LSU_rready  <= 1'b0;
            LSU_wvalid  <= 1'b0;
            LSU_wdata   <= 32'h0000_0000;
            LSU_wstrb   <= 4'b0000;
            LSU_bready  <= 1'b0;
            LSU_valid   <= 1'b0;
            LSU_result  <= 32'h0000_0000;
            LSU_err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (EXU_valid && LSU_ready) begin
                        LSU_ready <= 1'b0;
                        funct3_r  <= EXU_funct3;
                        a_lo_r    <= EXU_ALU_ALUout[1:0];
                        if (!mem_s) begin
                            LSU_result <= 32'(EXU_ALU_ALUout);
                            LSU_err    <= 1'b0;
                            LSU_valid  <= 1'b1;
                            state_r    <= DONE;
                        end else if (illegal_s || misalign_s) begin
                            LSU_result <= 32'h0000_0000;
                            LSU_err    <= 1'b1;
                            LSU_valid  <= 1'b1;
                            state_r    <= DONE;
                        end else if (EXU_load) begin
                            LSU_addr    <= {EXU_ALU_ALUout[ADDR_W-1:2], 2'b00};
                            LSU_arvalid <= 1'b1;
                            state_r     <= RD_REQ;
                        end else begin
                            LSU_addr   <= {EXU_ALU_ALUout[ADDR_W-1:2], 2'b00};
                            LSU_wdata  <= store_data(EXU_funct3, EXU_rs2_data);
                            LSU_wstrb  <= store_strb(EXU_funct3, EXU_ALU_ALUout[1:0]);
                            LSU_wvalid <= 1'b1;
                            state_r    <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (LSU_arready) begin
                        LSU_arvalid <= 1'b0;
                        LSU_rready  <= 1'b1;
                        state_r     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (LSU_rvalid) begin
                        LSU_rready <= 1'b0;
                        LSU_valid  <= 1'b1;
                        LSU_err    <= (LSU_rresp != 2'b00);
                        LSU_result <= (LSU_rresp != 2'b00) ? 32'h0000_0000
                                                           : load_extend(funct3_r, a_lo_r, LSU_rdata);
                        state_r    <= DONE;
                    end
                end
                WR_REQ: begin
                    if (LSU_wready) begin
                        LSU_wvalid <= 1'b0;
                        LSU_bready <= 1'b1;
                        state_r    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (LSU_bvalid) begin
                        LSU_bready <= 1'b0;
                        LSU_valid  <= 1'b1;
                        LSU_result <= 32'h0000_0000;
                        LSU_err    <= (LSU_bresp != 2'b00);
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    if (WBU_ready) begin
                        LSU_valid <= 1'b0;
                        LSU_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    LSU_ready   <= 1'b1;
                    LSU_arvalid <= 1'b0;
                    LSU_rready  <= 1'b0;
                    LSU_wvalid  <= 1'b0;
                    LSU_bready  <= 1'b0;
                    LSU_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_mem_lsu.sv
// Directed bench for the load/store unit: the bus and WBU sides are driven by hand
// and each scenario checks outputs cycle by cycle against hand-computed values.
module tb_ysyx_23060136_mem_lsu;

    logic        clk;
    logic        rst;
    logic        EXU_valid;
    logic        LSU_ready;
    logic [31:0] EXU_ALU_ALUout;
    logic [31:0] EXU_rs2_data;
    logic        EXU_load;
    logic        EXU_store;
    logic [2:0]  EXU_funct3;
    logic [31:0] LSU_addr;
    logic        LSU_arvalid;
    logic        LSU_arready;
    logic        LSU_rvalid;
    logic [31:0] LSU_rdata;
    logic [1:0]  LSU_rresp;
    logic        LSU_rready;
    logic        LSU_wvalid;
    logic [31:0] LSU_wdata;
    logic [3:0]  LSU_wstrb;
    logic        LSU_wready;
    logic        LSU_bvalid;
    logic [1:0]  LSU_bresp;
    logic        LSU_bready;
    logic        LSU_valid;
    logic        WBU_ready;
    logic [31:0] LSU_result;
    logic        LSU_err;

    int checks = 0;
    int errors = 0;

    ysyx_23060136_mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .EXU_valid(EXU_valid), .LSU_ready(LSU_ready),
        .EXU_ALU_ALUout(EXU_ALU_ALUout), .EXU_rs2_data(EXU_rs2_data),
        .EXU_load(EXU_load), .EXU_store(EXU_store), .EXU_funct3(EXU_funct3),
        .LSU_addr(LSU_addr), .LSU_arvalid(LSU_arvalid), .LSU_arready(LSU_arready),
        .LSU_rvalid(LSU_rvalid), .LSU_rdata(LSU_rdata), .LSU_rresp(LSU_rresp),
        .LSU_rready(LSU_rready), .LSU_wvalid(LSU_wvalid), .LSU_wdata(LSU_wdata),
        .LSU_wstrb(LSU_wstrb), .LSU_wready(LSU_wready), .LSU_bvalid(LSU_bvalid),
        .LSU_bresp(LSU_bresp), .LSU_bready(LSU_bready), .LSU_valid(LSU_valid),
        .WBU_ready(WBU_ready), .LSU_result(LSU_result), .LSU_err(LSU_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2);
        EXU_valid = 1'b1; EXU_load = ld; EXU_store = st; EXU_funct3 = f3;
        EXU_ALU_ALUout = a; EXU_rs2_data = rs2;
        step();
        EXU_valid = 1'b0; EXU_load = 1'b0; EXU_store = 1'b0;
    endtask

    task automatic retire(input string name);
        WBU_ready = 1'b1;
        step();
        WBU_ready = 1'b0;
        checks++;
        if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s retire: valid=%b ready=%b required valid=0 ready=1", name, LSU_valid, LSU_ready);
        end
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input int ar_delay, input logic [31:0] rdata, input logic [1:0] rresp,
                           input logic [31:0] exp_res, input logic exp_err);
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        issue(1'b1, 1'b0, f3, a, 32'h0000_0000);
        for (int i = 0; i <= ar_delay; i++) begin
            checks++;
            if (LSU_arvalid !== 1'b1 || LSU_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s ar[%0d]: arvalid=%b addr=%h required arvalid=1 addr=%h",
                         name, i, LSU_arvalid, LSU_addr, exp_addr);
            end
            if (i < ar_delay) step();
        end
        LSU_arready = 1'b1;
        step();
        LSU_arready = 1'b0;
        checks++;
        if (LSU_arvalid !== 1'b0 || LSU_rready !== 1'b1 || LSU_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rwait: arvalid=%b rready=%b valid=%b required 0 1 0",
                     name, LSU_arvalid, LSU_rready, LSU_valid);
        end
        LSU_rvalid = 1'b1; LSU_rdata = rdata; LSU_rresp = rresp;
        step();
        LSU_rvalid = 1'b0; LSU_rresp = 2'b00;
        checks++;
        if (LSU_valid !== 1'b1 || LSU_result !== exp_res || LSU_err !== exp_err || LSU_rready !== 1'b0) begin
            errors++;
            $display("FAIL %s result: valid=%b result=%h err=%b rready=%b required 1 %h %b 0",
                     name, LSU_valid, LSU_result, LSU_err, LSU_rready, exp_res, exp_err);
        end
        retire(name);
    endtask

    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rs2, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb, input logic [1:0] bresp, input logic exp_err);
        issue(1'b0, 1'b1, f3, a, rs2);
        checks++;
        if (LSU_wvalid !== 1'b1 || LSU_addr !== {a[31:2], 2'b00} ||
            LSU_wdata !== exp_wdata || LSU_wstrb !== exp_wstrb || LSU_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s wreq: wvalid=%b addr=%h wdata=%h wstrb=%b required 1 %h %h %b",
                     name, LSU_wvalid, LSU_addr, LSU_wdata, LSU_wstrb, {a[31:2], 2'b00}, exp_wdata, exp_wstrb);
        end
        LSU_wready = 1'b1;
        step();
        LSU_wready = 1'b0;
        checks++;
        if (LSU_wvalid !== 1'b0 || LSU_bready !== 1'b1) begin
            errors++;
            $display("FAIL %s bwait: wvalid=%b bready=%b required 0 1", name, LSU_wvalid, LSU_bready);
        end
        LSU_bvalid = 1'b1; LSU_bresp = bresp;
        step();
        LSU_bvalid = 1'b0; LSU_bresp = 2'b00;
        checks++;
        if (LSU_valid !== 1'b1 || LSU_err !== exp_err || LSU_result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL %s bresp: valid=%b err=%b result=%h required 1 %b 00000000",
                     name, LSU_valid, LSU_err, LSU_result, exp_err);
        end
        retire(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (LSU_ready !== 1'b1 || LSU_arvalid !== 1'b0 || LSU_rready !== 1'b0 || LSU_wvalid !== 1'b0 ||
            LSU_bready !== 1'b0 || LSU_valid !== 1'b0 || LSU_addr !== 32'h0 || LSU_wdata !== 32'h0 ||
            LSU_wstrb !== 4'h0 || LSU_result !== 32'h0 || LSU_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b arv=%b rr=%b wv=%b br=%b v=%b addr=%h wd=%h ws=%b res=%h err=%b",
                     LSU_ready, LSU_arvalid, LSU_rready, LSU_wvalid, LSU_bready, LSU_valid,
                     LSU_addr, LSU_wdata, LSU_wstrb, LSU_result, LSU_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (LSU_valid !== 1'b1 || LSU_result !== 32'h1234_5678 || LSU_err !== 1'b0 ||
                LSU_ready !== 1'b0 || LSU_arvalid !== 1'b0) begin
                errors++;
                $display("FAIL passthrough[%0d]: valid=%b result=%h err=%b ready=%b required 1 12345678 0 0",
                         i, LSU_valid, LSU_result, LSU_err, LSU_ready);
            end
            step();
        end
        retire("passthrough");
    endtask

    task automatic test_loads();
        do_load("lb",  3'b000, 32'h8000_0003, 0, 32'h80FF_0000, 2'b00, 32'hFFFF_FF80, 1'b0);
        do_load("lbu", 3'b100, 32'h8000_0003, 0, 32'h80FF_0000, 2'b00, 32'h0000_0080, 1'b0);
        do_load("lh",  3'b001, 32'h8000_0002, 0, 32'h80FF_0000, 2'b00, 32'hFFFF_80FF, 1'b0);
        do_load("lhu", 3'b101, 32'h8000_0000, 0, 32'h1234_F00D, 2'b00, 32'h0000_F00D, 1'b0);
        do_load("lw",  3'b010, 32'h8000_0010, 0, 32'hCAFE_BABE, 2'b00, 32'hCAFE_BABE, 1'b0);
    endtask

    task automatic test_stores();
        do_store("sh", 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 32'hBEEF_BEEF, 4'b1100, 2'b00, 1'b0);
        do_store("sb", 3'b000, 32'h8000_0001, 32'h1234_5678, 32'h7878_7878, 4'b0010, 2'b00, 1'b0);
        do_store("sw", 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 2'b01, 1'b1);
    endtask

    task automatic test_errors();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0);
        checks++;
        if (LSU_arvalid !== 1'b0 || LSU_valid !== 1'b1 || LSU_err !== 1'b1 || LSU_result !== 32'h0) begin
            errors++;
            $display("FAIL misalign_lw: arvalid=%b valid=%b err=%b result=%h required 0 1 1 00000000",
                     LSU_arvalid, LSU_valid, LSU_err, LSU_result);
        end
        retire("misalign_lw");
        issue(1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h0);
        checks++;
        if (LSU_wvalid !== 1'b0 || LSU_valid !== 1'b1 || LSU_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_f3: wvalid=%b valid=%b err=%b required 0 1 1", LSU_wvalid, LSU_valid, LSU_err);
        end
        retire("illegal_f3");
        do_load("backpressure", 3'b010, 32'h8000_0004, 4, 32'h1111_1111, 2'b10, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_stray_and_reset();
        LSU_rvalid = 1'b1; LSU_bvalid = 1'b1;
        step();
        LSU_rvalid = 1'b0; LSU_bvalid = 1'b0;
        checks++;
        if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_resp: valid=%b ready=%b required 0 1", LSU_valid, LSU_ready);
        end
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
        LSU_arready = 1'b1;
        step();
        LSU_arready = 1'b0;
        checks++;
        if (LSU_rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rwait: rready=%b required 1", LSU_rready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (LSU_arvalid !== 1'b0 || LSU_rready !== 1'b0 || LSU_valid !== 1'b0 || LSU_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: arvalid=%b rready=%b valid=%b ready=%b required 0 0 0 1",
                     LSU_arvalid, LSU_rready, LSU_valid, LSU_ready);
        end
        step();
        rst = 1'b0;
        issue(1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, 32'h0);
        checks++;
        if (LSU_valid !== 1'b1 || LSU_result !== 32'h0BAD_F00D || LSU_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: valid=%b result=%h err=%b required 1 0badf00d 0",
                     LSU_valid, LSU_result, LSU_err);
        end
        retire("after_reset");
    endtask

    initial begin
        rst = 1'b1; EXU_valid = 1'b0; EXU_ALU_ALUout = 32'h0; EXU_rs2_data = 32'h0;
        EXU_load = 1'b0; EXU_store = 1'b0; EXU_funct3 = 3'b000;
        LSU_arready = 1'b0; LSU_rvalid = 1'b0; LSU_rdata = 32'h0; LSU_rresp = 2'b00;
        LSU_wready = 1'b0; LSU_bvalid = 1'b0; LSU_bresp = 2'b00; WBU_ready = 1'b0;
        #1;
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_errors();
        test_stray_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
